// File: rtl/wm_phase_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : wm_phase_timer_if
//  Description : Request/response bundle between the washing-machine
//                controller (master) and the phase-duration timer (slave).
//                Controller -> timer : timer_enable, phase_sel, power_on
//                Timer -> controller : timer_done, remaining, busy
//  Parameters  : CNT_W - width of the remaining-seconds field
//  Revision    : 1.0 - initial release
// ============================================================================
interface wm_phase_timer_if #(
    parameter int CNT_W = 12
);
    logic             timer_enable;
    logic [1:0]       phase_sel;
    logic             power_on;
    logic             timer_done;
    logic [CNT_W-1:0] remaining;
    logic             busy;

    modport master (
        output timer_enable,
        output phase_sel,
        output power_on,
        input  timer_done,
        input  remaining,
        input  busy
    );

    modport slave (
        input  timer_enable,
        input  phase_sel,
        input  power_on,
        output timer_done,
        output remaining,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/wm_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wm_phase_timer
//  Description : Phase-duration timer for the washing-machine controller.
//                A prescaler makes one-second ticks, a down-counter tracks
//                the seconds left in the selected phase, and an IDLE/RUN/DONE
//                state machine reports completion. Everything freezes while
//                power_on is low so brown-outs neither lose nor skip time.
//  Ports       : clk    - system clock, posedge
//                rst_n  - synchronous active-low reset
//                tmr_if - slave side of wm_phase_timer_if
//                         (timer_enable, phase_sel, power_on in;
//                          timer_done, remaining, busy out)
//  Options     : WM_TIMER_FASTSIM_EN - when defined the prescaler is removed
//                and every powered clock edge in RUN is a one-second tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module wm_phase_timer #(
    parameter int CLK_DIV = 50000000,
    parameter int CNT_W   = 12,
    parameter int SOAK_T  = 600,
    parameter int WASH_T  = 900,
    parameter int RINSE_T = 300,
    parameter int SPIN_T  = 240
) (
    input  wire               clk,
    input  wire               rst_n,
    wm_phase_timer_if.slave   tmr_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_remaining;
    logic [1:0]       r_phase_q;

    logic             w_tick;
    logic             w_run_step;
    logic             w_phase_match;
    logic [CNT_W-1:0] w_dur;

    // Programmed duration of the requested phase, truncated to CNT_W bits.
    function automatic logic [CNT_W-1:0] f_dur(input logic [1:0] sel);
        logic [CNT_W-1:0] v;
        case (sel)
            2'b00:   v = CNT_W'(SOAK_T);
            2'b01:   v = CNT_W'(WASH_T);
            2'b10:   v = CNT_W'(RINSE_T);
            default: v = CNT_W'(SPIN_T);
        endcase
        return v;
    endfunction

    assign w_dur         = f_dur(tmr_if.phase_sel);
    assign w_phase_match = (tmr_if.phase_sel == r_phase_q);

    // A counting edge: powered, in RUN, and the controller still asks for the
    // same phase. Any other powered edge parks the prescaler at zero.
    assign w_run_step = tmr_if.power_on && (r_state == S_RUN) &&
                        tmr_if.timer_enable && w_phase_match;

`ifdef WM_TIMER_FASTSIM_EN
    assign w_tick = 1'b1;
`else
    localparam int                 PRESC_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] r_presc;

    assign w_tick = (r_presc == C_PRESC_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (tmr_if.power_on) begin
            if (w_run_step && !w_tick) begin
                r_presc <= r_presc + 1'b1;
            end else begin
                r_presc <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_phase_q   <= 2'b00;
        end else if (tmr_if.power_on) begin
            case (r_state)
                S_IDLE: begin
                    if (tmr_if.timer_enable) begin
                        r_remaining <= w_dur;
                        r_phase_q   <= tmr_if.phase_sel;
                        r_state     <= (w_dur != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN, S_DONE: begin
                    if (!tmr_if.timer_enable) begin
                        r_state     <= S_IDLE;
                        r_remaining <= '0;
                    end else if (!w_phase_match) begin
                        // Controller moved on: restart for the new phase.
                        r_remaining <= w_dur;
                        r_phase_q   <= tmr_if.phase_sel;
                        r_state     <= (w_dur != '0) ? S_RUN : S_DONE;
                    end else if (r_state == S_RUN) begin
                        // Decrement only from nonzero so the count never wraps.
                        if (w_tick && (r_remaining != '0)) begin
                            r_remaining <= r_remaining - CNT_W'(1);
                            if (r_remaining == CNT_W'(1)) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_remaining <= '0;
                end
            endcase
        end
    end

    // Done is gated by the live request so it drops the instant the
    // controller advances, never leaking into the next phase.
    assign tmr_if.timer_done = (r_state == S_DONE) && tmr_if.timer_enable && w_phase_match;
    assign tmr_if.busy       = (r_state == S_RUN);
    assign tmr_if.remaining  = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_wm_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wm_phase_timer
//  Description : Directed self-checking bench for wm_phase_timer with
//                CLK_DIV=4, SOAK_T=3, WASH_T=5, RINSE_T=2, SPIN_T=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_phase_timer;

    localparam int CNT_W = 12;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wm_phase_timer_if #(.CNT_W(CNT_W)) tmr ();

    wm_phase_timer #(
        .CLK_DIV (4),
        .CNT_W   (CNT_W),
        .SOAK_T  (3),
        .WASH_T  (5),
        .RINSE_T (2),
        .SPIN_T  (0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tmr_if (tmr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        tmr.timer_enable = 1'b1;
        tmr.phase_sel    = 2'b00;
        tmr.power_on     = 1'b1;
        step();
        step();
        n_checks++;
        if (tmr.remaining !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_remaining: got %0d want 0", tmr.remaining);
        end
        n_checks++;
        if (tmr.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", tmr.busy);
        end
        n_checks++;
        if (tmr.timer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 0", tmr.timer_done);
        end
        tmr.timer_enable = 1'b0;
        rst_n            = 1'b1;
        step();
    endtask

    // Soak: load at E0, remaining 3,2,1,0 after E4,E8,E12, done from E12.
    task automatic test_soak_run();
        int exp_rem;
        tmr.phase_sel    = 2'b00;
        tmr.timer_enable = 1'b1;
        step();
        n_checks++;
        if (tmr.remaining !== 12'd3 || tmr.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL soak_load: got rem=%0d busy=%b want rem=3 busy=1", tmr.remaining, tmr.busy);
        end
        for (int e = 1; e <= 12; e++) begin
            step();
            exp_rem = 3 - e / 4;
            n_checks++;
            if (tmr.remaining !== CNT_W'(exp_rem)) begin
                n_fail++;
                $display("FAIL soak_rem_E%0d: got %0d want %0d", e, tmr.remaining, exp_rem);
            end
            n_checks++;
            if (tmr.busy !== (e < 12) || tmr.timer_done !== (e >= 12)) begin
                n_fail++;
                $display("FAIL soak_flags_E%0d: got busy=%b done=%b want busy=%b done=%b",
                         e, tmr.busy, tmr.timer_done, (e < 12), (e >= 12));
            end
        end
        step();
        step();
        n_checks++;
        if (tmr.timer_done !== 1'b1 || tmr.remaining !== 12'd0) begin
            n_fail++;
            $display("FAIL soak_done_hold: got done=%b rem=%0d want done=1 rem=0", tmr.timer_done, tmr.remaining);
        end
        tmr.power_on = 1'b0;
        step();
        step();
        n_checks++;
        if (tmr.timer_done !== 1'b1) begin
            n_fail++;
            $display("FAIL soak_done_unpowered: got %b want 1", tmr.timer_done);
        end
        tmr.power_on = 1'b1;
        step();
    endtask

    // In DONE, moving to wash kills done combinationally and reloads next edge.
    task automatic test_phase_change();
        tmr.phase_sel = 2'b01;
        #1;
        n_checks++;
        if (tmr.timer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL change_done_drop: got %b want 0", tmr.timer_done);
        end
        step();
        n_checks++;
        if (tmr.remaining !== 12'd5 || tmr.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL change_reload: got rem=%0d busy=%b want rem=5 busy=1", tmr.remaining, tmr.busy);
        end
    endtask

    // Cancel the running wash: IDLE next edge, done never appears.
    task automatic test_cancel();
        logic saw_done;
        step();
        step();
        tmr.timer_enable = 1'b0;
        step();
        n_checks++;
        if (tmr.remaining !== 12'd0 || tmr.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_idle: got rem=%0d busy=%b want rem=0 busy=0", tmr.remaining, tmr.busy);
        end
        saw_done = 1'b0;
        for (int e = 0; e < 25; e++) begin
            step();
            if (tmr.timer_done !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_no_done: got done seen=%b want 0", saw_done);
        end
    endtask

    // Power freeze of 10 edges after E5 pushes done from E12 to E22.
    task automatic test_freeze();
        tmr.phase_sel    = 2'b00;
        tmr.timer_enable = 1'b1;
        step();
        for (int e = 1; e <= 5; e++) step();
        n_checks++;
        if (tmr.remaining !== 12'd2) begin
            n_fail++;
            $display("FAIL freeze_pre: got rem=%0d want 2", tmr.remaining);
        end
        tmr.power_on = 1'b0;
        for (int e = 6; e <= 15; e++) begin
            // Request changes while unpowered must be ignored.
            tmr.phase_sel = (e == 8 || e == 9) ? 2'b10 : 2'b00;
            step();
        end
        n_checks++;
        if (tmr.remaining !== 12'd2 || tmr.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_hold: got rem=%0d busy=%b want rem=2 busy=1", tmr.remaining, tmr.busy);
        end
        tmr.power_on = 1'b1;
        for (int e = 16; e <= 21; e++) step();
        n_checks++;
        if (tmr.remaining !== 12'd1 || tmr.timer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_E21: got rem=%0d done=%b want rem=1 done=0", tmr.remaining, tmr.timer_done);
        end
        step();
        n_checks++;
        if (tmr.remaining !== 12'd0 || tmr.timer_done !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_E22: got rem=%0d done=%b want rem=0 done=1", tmr.remaining, tmr.timer_done);
        end
        tmr.timer_enable = 1'b0;
        step();
    endtask

    // Rinse load, then switch to zero-length spin mid-RUN: straight to DONE.
    task automatic test_zero_dur();
        tmr.phase_sel    = 2'b10;
        tmr.timer_enable = 1'b1;
        step();
        n_checks++;
        if (tmr.remaining !== 12'd2 || tmr.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rinse_load: got rem=%0d busy=%b want rem=2 busy=1", tmr.remaining, tmr.busy);
        end
        step();
        tmr.phase_sel = 2'b11;
        step();
        n_checks++;
        if (tmr.timer_done !== 1'b1 || tmr.busy !== 1'b0 || tmr.remaining !== 12'd0) begin
            n_fail++;
            $display("FAIL spin_zero_done: got done=%b busy=%b rem=%0d want done=1 busy=0 rem=0",
                     tmr.timer_done, tmr.busy, tmr.remaining);
        end
        tmr.timer_enable = 1'b0;
        #1;
        n_checks++;
        if (tmr.timer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL spin_done_drop: got %b want 0", tmr.timer_done);
        end
        step();
    endtask

    // Reset mid-RUN at remaining=2 clears everything; release reloads.
    task automatic test_reset_midrun();
        tmr.phase_sel    = 2'b00;
        tmr.timer_enable = 1'b1;
        step();
        for (int e = 1; e <= 4; e++) step();
        n_checks++;
        if (tmr.remaining !== 12'd2) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got rem=%0d want 2", tmr.remaining);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (tmr.remaining !== 12'd0 || tmr.busy !== 1'b0 || tmr.timer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got rem=%0d busy=%b done=%b want 0 0 0",
                     tmr.remaining, tmr.busy, tmr.timer_done);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (tmr.remaining !== 12'd3 || tmr.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_reload: got rem=%0d busy=%b want rem=3 busy=1", tmr.remaining, tmr.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_soak_run();
        test_phase_change();
        test_cancel();
        test_freeze();
        test_zero_dur();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
